collision_up_detect: RTL and testbench



---
 rtl/collide_pkg.sv | 18 +
 rtl/collision_up_detect_if.sv | 32 +++
 rtl/box_overlap.sv | 25 ++
 rtl/collision_up_detect.sv | 116 +++++++++++
 tb/tb_collision_up_detect.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/collide_pkg.sv
// Shared types and helpers for the upward-collision detector.
// Holds the FSM state encoding, the default coordinate width and the absolute-difference helper.
package collide_pkg;

  typedef enum logic [1:0] {IDLE, HIT, COOL, REARM} collide_state_t;

  localparam int CW_DEF = 10;
  localparam int AW     = 16;

  // Zero-extended operands, so a far-apart pair never wraps to a small distance.
  function automatic logic [AW:0] abs_diff(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic signed [AW:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) return $unsigned(-d);
    else       return $unsigned(d);
  endfunction

endpackage

// File: rtl/collision_up_detect_if.sv
// Bus between the game logic and the upward-collision detector.
// Optional hit_count signal is present only when COLLIDE_HIT_COUNT_EN is defined.
interface collision_up_detect_if import collide_pkg::*; #(
  parameter int CW      = CW_DEF,
  parameter int NUM_TGT = 4
);
  localparam int IW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

  logic                    frame_clk;
  logic                    clear;
  logic [CW-1:0]           player_x;
  logic [CW-1:0]           player_y;
  logic [CW-1:0]           player_vy;
  logic [NUM_TGT*2*CW-1:0] tgt_xy;
  logic [NUM_TGT-1:0]      tgt_en;
  logic                    collisonUp;
  logic [IW-1:0]           hit_idx;
`ifdef COLLIDE_HIT_COUNT_EN
  logic [15:0]             hit_count;

  modport master (output frame_clk, clear, player_x, player_y, player_vy, tgt_xy, tgt_en,
                  input collisonUp, hit_idx, hit_count);
  modport slave  (input frame_clk, clear, player_x, player_y, player_vy, tgt_xy, tgt_en,
                  output collisonUp, hit_idx, hit_count);
`else
  modport master (output frame_clk, clear, player_x, player_y, player_vy, tgt_xy, tgt_en,
                  input collisonUp, hit_idx);
  modport slave  (input frame_clk, clear, player_x, player_y, player_vy, tgt_xy, tgt_en,
                  output collisonUp, hit_idx);
`endif

endinterface

// File: rtl/box_overlap.sv
// Combinational test of one player box against one target box.
// Boxes touch when both axis distances are within PSIZE+TSIZE.
module box_overlap import collide_pkg::*; #(
  parameter int CW    = CW_DEF,
  parameter int PSIZE = 8,
  parameter int TSIZE = 8
) (
  input  logic [CW-1:0] px,
  input  logic [CW-1:0] py,
  input  logic [CW-1:0] tx,
  input  logic [CW-1:0] ty,
  input  logic          en,
  output logic          overlap
);
  localparam int          LIM_I = PSIZE + TSIZE;
  localparam logic [AW:0] LIM   = LIM_I[AW:0];

  logic [AW:0] dx;
  logic [AW:0] dy;

  assign dx      = abs_diff(AW'(px), AW'(tx));
  assign dy      = abs_diff(AW'(py), AW'(ty));
  assign overlap = en & (dx <= LIM) & (dy <= LIM);

endmodule

// File: rtl/collision_up_detect.sv
// Detects upward player/target contact once per frame and emits a one-frame collisonUp strobe.
// Defining COLLIDE_HIT_COUNT_EN adds a saturating 16-bit hit counter on the bus.
module collision_up_detect import collide_pkg::*; #(
  parameter int CW      = CW_DEF,
  parameter int NUM_TGT = 4,
  parameter int PSIZE   = 8,
  parameter int TSIZE   = 8,
  parameter int COOL_FR = 8
) (
  input logic                 Clk,
  input logic                 Reset,
  collision_up_detect_if.slave bus
);
  localparam int IW   = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int CNTW = (COOL_FR > 1) ? $clog2(COOL_FR) : 1;
  localparam int CLD  = COOL_FR - 1;

  logic               rst_all;
  logic               frame_q;
  logic               tick;
  logic [NUM_TGT-1:0] ovl;
  logic               any_ovl;
  logic               up_hit;
  logic [IW-1:0]      win_idx;

  collide_state_t     state, state_n;
  logic [CNTW-1:0]    cnt, cnt_n;
  logic               strobe, strobe_n;
  logic [IW-1:0]      idx, idx_n;
  logic               hit_inc;

  assign rst_all = Reset | bus.clear;
  assign tick    = bus.frame_clk & ~frame_q;

  for (genvar i = 0; i < NUM_TGT; i++) begin : g_tgt
    box_overlap #(.CW(CW), .PSIZE(PSIZE), .TSIZE(TSIZE)) u_ovl (
      .px      (bus.player_x),
      .py      (bus.player_y),
      .tx      (bus.tgt_xy[i*2*CW+CW +: CW]),
      .ty      (bus.tgt_xy[i*2*CW +: CW]),
      .en      (bus.tgt_en[i]),
      .overlap (ovl[i])
    );
  end

  assign any_ovl = |ovl;
  assign up_hit  = any_ovl & bus.player_vy[CW-1];

  // Scan downward so the lowest overlapping index is the last written.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if (ovl[i]) win_idx = IW'(i);
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    strobe_n = strobe;
    idx_n    = idx;
    hit_inc  = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: if (up_hit) begin
          state_n  = HIT;
          strobe_n = 1'b1;
          idx_n    = win_idx;
          hit_inc  = 1'b1;
        end
        HIT: begin
          state_n  = COOL;
          strobe_n = 1'b0;
          cnt_n    = CLD[CNTW-1:0];
        end
        COOL: begin
          if (cnt == '0) state_n = REARM;
          else           cnt_n   = cnt - 1'b1;
        end
        REARM: if (!any_ovl) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (rst_all) begin
      frame_q <= 1'b0;
      state   <= IDLE;
      cnt     <= '0;
      strobe  <= 1'b0;
      idx     <= '0;
    end else begin
      frame_q <= bus.frame_clk;
      state   <= state_n;
      cnt     <= cnt_n;
      strobe  <= strobe_n;
      idx     <= idx_n;
    end
  end

  assign bus.collisonUp = strobe;
  assign bus.hit_idx    = idx;

`ifdef COLLIDE_HIT_COUNT_EN
  logic [15:0] hit_count_q;

  always_ff @(posedge Clk) begin
    if (rst_all)                                 hit_count_q <= '0;
    else if (hit_inc && hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
  end

  assign bus.hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_collision_up_detect.sv
// Directed bench for collision_up_detect: vector table of single-frame contacts plus
// hand sequences for reset, strobe length, cooldown/re-arm and clear behaviour.
module tb_collision_up_detect;
  import collide_pkg::*;

  localparam int CW = 10;
  localparam int NT = 4;
  localparam logic [NT*2*CW-1:0] FAR = {NT{10'd500, 10'd500}};
  localparam logic [CW-1:0] VUP = 10'h3FE;
  localparam logic [CW-1:0] VDN = 10'd2;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  collision_up_detect_if #(.CW(CW), .NUM_TGT(NT)) bus ();

  collision_up_detect #(.CW(CW), .NUM_TGT(NT), .PSIZE(8), .TSIZE(8), .COOL_FR(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic [CW-1:0]      px, py, vy;
    logic [NT*2*CW-1:0] txy;
    logic [NT-1:0]      en;
    logic               exp_hit;
    logic [1:0]         exp_idx;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  int   rises;
  logic prev;

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic frame();
    bus.frame_clk = 1'b1;
    step(1);
    bus.frame_clk = 1'b0;
    step(3);
  endtask

  function automatic logic [NT*2*CW-1:0] put(input logic [NT*2*CW-1:0] base, input int i,
                                             input logic [CW-1:0] x, input logic [CW-1:0] y);
    logic [NT*2*CW-1:0] r;
    r = base;
    r[i*2*CW +: 2*CW] = {x, y};
    return r;
  endfunction

  task automatic add(input logic [CW-1:0] px, input logic [CW-1:0] py, input logic [CW-1:0] vy,
                     input logic [NT*2*CW-1:0] txy, input logic [NT-1:0] en,
                     input logic h, input logic [1:0] idx);
    vec_t v;
    v.px = px; v.py = py; v.vy = vy; v.txy = txy; v.en = en; v.exp_hit = h; v.exp_idx = idx;
    vecs.push_back(v);
  endtask

  task automatic set_in(input logic [CW-1:0] px, input logic [CW-1:0] py, input logic [CW-1:0] vy,
                        input logic [NT*2*CW-1:0] txy, input logic [NT-1:0] en);
    bus.player_x = px; bus.player_y = py; bus.player_vy = vy; bus.tgt_xy = txy; bus.tgt_en = en;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
  endtask

  initial begin
    add(100, 100, VUP, FAR,                                               4'hF, 0, 0);
    add(100, 100, VUP, put(FAR, 0, 100, 110),                             4'h1, 1, 0);
    add(100, 100, VUP, put(put(FAR, 1, 105, 95), 3, 90, 100),             4'hA, 1, 1);
    add(100, 100, VUP, put(put(FAR, 1, 105, 95), 3, 90, 100),             4'h8, 1, 3);
    add(100, 100, VDN, put(put(FAR, 1, 105, 95), 3, 90, 100),             4'hA, 0, 0);
    add(100, 100, 0,   put(put(FAR, 1, 105, 95), 3, 90, 100),             4'hA, 0, 0);
    add(100, 100, VUP, put(FAR, 2, 116, 100),                             4'h4, 1, 2);
    add(100, 100, VUP, put(FAR, 2, 117, 100),                             4'h4, 0, 0);
    add(100, 100, VUP, put(FAR, 0, 84, 100),                              4'h1, 1, 0);
    add(100, 100, VUP, put(FAR, 0, 100, 117),                             4'h1, 0, 0);
    add(0,   100, VUP, put(FAR, 1, 1000, 100),                            4'h2, 0, 0);
    add(0,   100, VUP, put(FAR, 1, 1016, 100),                            4'h2, 0, 0);
    add(100, 100, VUP, put(FAR, 0, 100, 110),                             4'h0, 0, 0);

    // Reset held three cycles, then quiet frames
    Reset = 1'b1; bus.clear = 1'b0; bus.frame_clk = 1'b0;
    set_in(100, 100, VUP, FAR, 4'hF);
    step(3);
    Reset = 1'b0;
    check("rst_strobe", 32'(bus.collisonUp), 0);
    check("rst_idx",    32'(bus.hit_idx),    0);
    check("rst_state",  32'(dut.state),      32'(IDLE));
    for (int f = 0; f < 3; f++) begin
      frame();
      check($sformatf("quiet%0d", f), 32'(bus.collisonUp), 0);
    end

    // Single-frame vector table
    for (int k = 0; k < vecs.size(); k++) begin
      pulse_clear();
      set_in(vecs[k].px, vecs[k].py, vecs[k].vy, vecs[k].txy, vecs[k].en);
      frame();
      check($sformatf("vec%0d_hit", k), 32'(bus.collisonUp), 32'(vecs[k].exp_hit));
      check($sformatf("vec%0d_idx", k), 32'(bus.hit_idx),    32'(vecs[k].exp_idx));
    end

    // Strobe spans exactly one frame
    pulse_clear();
    set_in(100, 100, VUP, put(FAR, 0, 100, 110), 4'h1);
    bus.frame_clk = 1'b1;
    step(1);
    check("len_first", 32'(bus.collisonUp), 1);
    bus.frame_clk = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(1);
      check($sformatf("len_hold%0d", c), 32'(bus.collisonUp), 1);
    end
    bus.frame_clk = 1'b1;
    step(1);
    check("len_end", 32'(bus.collisonUp), 0);
    bus.frame_clk = 1'b0;
    step(2);

    // Held overlap for 20 frames yields one strobe, then re-arm on release
    pulse_clear();
    rises = 0;
    prev  = 1'b0;
    for (int f = 0; f < 20; f++) begin
      bus.frame_clk = 1'b1;
      for (int c = 0; c < 4; c++) begin
        step(1);
        bus.frame_clk = 1'b0;
        if (bus.collisonUp && !prev) rises++;
        prev = bus.collisonUp;
      end
    end
    check("held_rises", 32'(rises), 1);
    check("held_rearm", 32'(dut.state), 32'(REARM));
    bus.tgt_xy = FAR;
    frame();
    check("release_idle",   32'(dut.state),      32'(IDLE));
    check("release_strobe", 32'(bus.collisonUp), 0);
    bus.tgt_xy = put(FAR, 0, 100, 110);
    frame();
    check("recontact", 32'(bus.collisonUp), 1);

    // Clear during the HIT frame truncates the strobe
    pulse_clear();
    set_in(100, 100, VUP, put(FAR, 2, 100, 110), 4'h4);
    frame();
    check("clr_pre_strobe", 32'(bus.collisonUp), 1);
    check("clr_pre_idx",    32'(bus.hit_idx),    2);
`ifdef COLLIDE_HIT_COUNT_EN
    check("clr_pre_count",  32'(bus.hit_count),  1);
`endif
    bus.clear = 1'b1;
    step(1);
    check("clr_strobe", 32'(bus.collisonUp), 0);
    check("clr_idx",    32'(bus.hit_idx),    0);
    check("clr_state",  32'(dut.state),      32'(IDLE));
`ifdef COLLIDE_HIT_COUNT_EN
    check("clr_count",  32'(bus.hit_count),  0);
`endif

    // Tick arriving as clear deasserts is processed
    bus.frame_clk = 1'b1;
    step(1);
    check("clr_tick_held", 32'(bus.collisonUp), 0);
    bus.clear = 1'b0;
    step(1);
    check("clr_tick_hit", 32'(bus.collisonUp), 1);
    bus.frame_clk = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
